// File: rtl/spi_regmap_pkg.sv
// Register map, frame layout and FSM encoding shared by the SPI register bank.
package spi_regmap_pkg;

  localparam int unsigned FRAME_BITS = 16;
  localparam int unsigned MAX_ADDR   = 4;
  localparam int unsigned ADDR_W     = 7;
  localparam int unsigned DATA_W     = 8;

  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_LO = 7'h00;
  localparam logic [ADDR_W-1:0] ADDR_EN_OUT_HI = 7'h01;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_LO = 7'h02;
  localparam logic [ADDR_W-1:0] ADDR_EN_PWM_HI = 7'h03;
  localparam logic [ADDR_W-1:0] ADDR_DUTY      = 7'h04;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_SHIFT  = 2'd1,
    ST_COMMIT = 2'd2
  } state_e;

  // One SPI frame as it sits in the shift register after 16 bits
  typedef struct packed {
    logic              rw;
    logic [ADDR_W-1:0] addr;
    logic [DATA_W-1:0] data;
  } frame_t;

endpackage

// File: rtl/sync_edge.sv
// Multi-flop synchroniser with rise/fall pulses taken from the last stage.
module sync_edge #(
  parameter int unsigned STAGES  = 2,
  parameter logic        RST_VAL = 1'b0
) (
  input  logic clk,
  input  logic rst_n,
  input  logic d_i,
  output logic s_o,
  output logic rise_c_o,
  output logic fall_c_o
);

  logic [STAGES-1:0] sync_q;
  logic              last_q;

  // Synchroniser chain plus one history flop, preset to the pin's idle level
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q <= {STAGES{RST_VAL}};
      last_q <= RST_VAL;
    end else begin
      sync_q <= {sync_q[STAGES-2:0], d_i};
      last_q <= sync_q[STAGES-1];
    end
  end

  assign s_o      = sync_q[STAGES-1];
  assign rise_c_o = sync_q[STAGES-1] & ~last_q;
  assign fall_c_o = ~sync_q[STAGES-1] & last_q;

endmodule

// File: rtl/spi_reg_bank.sv
// SPI mode-0 write-only register bank driving the PWM control inputs.
module spi_reg_bank
  import spi_regmap_pkg::*;
#(
  parameter int unsigned SYNC_STAGES = 2
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ncs,
  input  logic       sclk,
  input  logic       copi,
  output logic [7:0] en_out_7_0,
  output logic [7:0] en_out_15_8,
  output logic [7:0] en_pwm_7_0,
  output logic [7:0] en_pwm_15_8,
  output logic [7:0] pwm_duty_cycle,
  output logic       wr_pulse
);

  localparam int unsigned       CNT_W    = 5;
  localparam logic [CNT_W-1:0]  CNT_FULL = CNT_W'(FRAME_BITS);
  localparam logic [CNT_W-1:0]  CNT_SAT  = CNT_W'(FRAME_BITS + 1);

  logic ncs_s, ncs_rise_c, ncs_fall_c;
  logic sclk_s, sclk_rise_c, sclk_fall_c;
  logic copi_s, copi_rise_c, copi_fall_c;
  logic unused_c;

  state_e                  state_q;
  logic [CNT_W-1:0]        cnt_q;
  logic [FRAME_BITS-1:0]   sr_q;
  logic [DATA_W-1:0]       en_out_lo_q, en_out_hi_q, en_pwm_lo_q, en_pwm_hi_q, duty_q;
  logic                    wr_pulse_q;

  frame_t frame_c;
  logic   wr_ok_c;

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b1)) u_sync_ncs (
    .clk(clk), .rst_n(rst_n), .d_i(ncs),
    .s_o(ncs_s), .rise_c_o(ncs_rise_c), .fall_c_o(ncs_fall_c)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_sclk (
    .clk(clk), .rst_n(rst_n), .d_i(sclk),
    .s_o(sclk_s), .rise_c_o(sclk_rise_c), .fall_c_o(sclk_fall_c)
  );

  sync_edge #(.STAGES(SYNC_STAGES), .RST_VAL(1'b0)) u_sync_copi (
    .clk(clk), .rst_n(rst_n), .d_i(copi),
    .s_o(copi_s), .rise_c_o(copi_rise_c), .fall_c_o(copi_fall_c)
  );

  // Synchroniser outputs this block has no use for
  assign unused_c = ^{sclk_s, sclk_fall_c, copi_rise_c, copi_fall_c};

  // Frame validity: exactly 16 bits, write flag set, implemented address
  always_comb begin
    frame_c = frame_t'(sr_q);
    wr_ok_c = (cnt_q == CNT_FULL) && frame_c.rw &&
              (frame_c.addr <= ADDR_W'(MAX_ADDR));
  end

  // Frame FSM, deserialiser and register file
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      cnt_q       <= '0;
      sr_q        <= '0;
      en_out_lo_q <= '0;
      en_out_hi_q <= '0;
      en_pwm_lo_q <= '0;
      en_pwm_hi_q <= '0;
      duty_q      <= '0;
      wr_pulse_q  <= 1'b0;
    end else begin
      wr_pulse_q <= 1'b0;
      case (state_q)
        ST_IDLE: begin
          if (ncs_fall_c) begin
            state_q <= ST_SHIFT;
            cnt_q   <= '0;
            sr_q    <= '0;
          end
        end
        ST_SHIFT: begin
          // A deselect wins over an sclk edge seen in the same clock
          if (ncs_rise_c) begin
            state_q <= ST_COMMIT;
          end else if (sclk_rise_c && !ncs_s) begin
            sr_q <= {sr_q[FRAME_BITS-2:0], copi_s};
            if (cnt_q != CNT_SAT) begin
              cnt_q <= cnt_q + CNT_W'(1);
            end
          end
        end
        ST_COMMIT: begin
          if (wr_ok_c) begin
            wr_pulse_q <= 1'b1;
            case (frame_c.addr)
              ADDR_EN_OUT_LO: en_out_lo_q <= frame_c.data;
              ADDR_EN_OUT_HI: en_out_hi_q <= frame_c.data;
              ADDR_EN_PWM_LO: en_pwm_lo_q <= frame_c.data;
              ADDR_EN_PWM_HI: en_pwm_hi_q <= frame_c.data;
              ADDR_DUTY:      duty_q      <= frame_c.data;
              default: ;
            endcase
          end
          // A new select arriving during commit is not lost
          if (ncs_fall_c) begin
            state_q <= ST_SHIFT;
            cnt_q   <= '0;
            sr_q    <= '0;
          end else begin
            state_q <= ST_IDLE;
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign en_out_7_0     = en_out_lo_q;
  assign en_out_15_8    = en_out_hi_q;
  assign en_pwm_7_0     = en_pwm_lo_q;
  assign en_pwm_15_8    = en_pwm_hi_q;
  assign pwm_duty_cycle = duty_q;
  assign wr_pulse       = wr_pulse_q;

endmodule

// File: tb/tb_spi_reg_bank.sv
// Self-checking bench for spi_reg_bank: table of frames plus reset corner sequences.
module tb_spi_reg_bank;

  localparam int SYNC = 2;
  localparam int HALF = 5;   // clks per sclk half period

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       ncs = 1'b1;
  logic       sclk = 1'b0;
  logic       copi = 1'b0;
  logic [7:0] en_out_7_0, en_out_15_8, en_pwm_7_0, en_pwm_15_8, pwm_duty_cycle;
  logic       wr_pulse;

  spi_reg_bank #(.SYNC_STAGES(SYNC)) dut (
    .clk(clk), .rst_n(rst_n), .ncs(ncs), .sclk(sclk), .copi(copi),
    .en_out_7_0(en_out_7_0), .en_out_15_8(en_out_15_8),
    .en_pwm_7_0(en_pwm_7_0), .en_pwm_15_8(en_pwm_15_8),
    .pwm_duty_cycle(pwm_duty_cycle), .wr_pulse(wr_pulse)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [63:0] val;
    int          nbits;
    bit          coinc;
    bit          pulse;
    logic [39:0] regs;
  } vec_t;

  typedef struct {
    bit          pulse;
    logic [39:0] regs;
  } exp_t;

  vec_t vecs[13];
  exp_t exp_q[$];

  int total = 0;
  int bad = 0;
  int cyc = 0;
  int pulse_cnt = 0;
  int last_pulse_cyc = -1;
  int raise_cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  // Strobe monitor sampled away from the active edge
  always @(negedge clk) begin
    if (wr_pulse === 1'b1) begin
      pulse_cnt      <= pulse_cnt + 1;
      last_pulse_cyc <= cyc;
    end
  end

  function automatic logic [39:0] regs_now();
    return {en_out_7_0, en_out_15_8, en_pwm_7_0, en_pwm_15_8, pwm_duty_cycle};
  endfunction

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic shift_bits(input logic [63:0] val, input int nbits);
    for (int i = nbits - 1; i >= 0; i--) begin
      copi = val[i];
      clks(HALF);
      sclk = 1'b1;
      clks(HALF);
      sclk = 1'b0;
    end
  endtask

  task automatic run_frame(input string name, input logic [63:0] val, input int nbits,
                           input bit coinc, input bit exp_pulse, input logic [39:0] exp_regs);
    exp_t e;
    exp_t got;
    int   p0;
    e.pulse = exp_pulse;
    e.regs  = exp_regs;
    exp_q.push_back(e);
    p0 = pulse_cnt;
    ncs = 1'b0;
    clks(HALF);
    shift_bits(val, nbits);
    clks(HALF);
    if (coinc) begin
      copi = 1'b0;
      sclk = 1'b1;
    end
    ncs = 1'b1;
    raise_cyc = cyc;
    clks(HALF);
    sclk = 1'b0;
    clks(7);
    if (exp_q.size() == 0) begin
      check({name, " scoreboard"}, 64'd0, 64'd1);
    end else begin
      got = exp_q.pop_front();
      check({name, " pulses"}, 64'(pulse_cnt - p0), 64'(got.pulse));
      if (got.pulse)
        check({name, " latency"}, 64'(last_pulse_cyc - raise_cyc), 64'(SYNC + 2));
      check({name, " regs"}, 64'(regs_now()), 64'(got.regs));
    end
  endtask

  initial begin
    int p0;

    //            value                 bits coinc pulse regs {eo_lo,eo_hi,ep_lo,ep_hi,duty}
    vecs[0]  = '{64'h8455,              16, 1'b0, 1'b1, 40'h00_00_00_00_55};
    vecs[1]  = '{64'h80F0,              16, 1'b0, 1'b1, 40'hF0_00_00_00_55};
    vecs[2]  = '{64'h81A5,              16, 1'b0, 1'b1, 40'hF0_A5_00_00_55};
    vecs[3]  = '{64'h820F,              16, 1'b0, 1'b1, 40'hF0_A5_0F_00_55};
    vecs[4]  = '{64'h83C3,              16, 1'b0, 1'b1, 40'hF0_A5_0F_C3_55};
    vecs[5]  = '{64'h04AA,              16, 1'b0, 1'b0, 40'hF0_A5_0F_C3_55};
    vecs[6]  = '{64'h85FF,              16, 1'b0, 1'b0, 40'hF0_A5_0F_C3_55};
    vecs[7]  = '{64'hFF12,              16, 1'b0, 1'b0, 40'hF0_A5_0F_C3_55};
    vecs[8]  = '{64'h4233,              15, 1'b0, 1'b0, 40'hF0_A5_0F_C3_55};
    vecs[9]  = '{64'h18466,             17, 1'b0, 1'b0, 40'hF0_A5_0F_C3_55};
    vecs[10] = '{64'h0000_FFFF_0000_8499, 48, 1'b0, 1'b0, 40'hF0_A5_0F_C3_55};
    vecs[11] = '{64'h8400,              16, 1'b0, 1'b1, 40'hF0_A5_0F_C3_00};
    vecs[12] = '{64'h8488,              16, 1'b1, 1'b1, 40'hF0_A5_0F_C3_88};

    // Reset held while pins toggle
    clks(3);
    ncs = 1'b0;
    repeat (4) begin
      sclk = 1'b1; copi = 1'b1; clks(2);
      sclk = 1'b0; clks(2);
    end
    ncs = 1'b1;
    copi = 1'b0;
    check("reset regs", 64'(regs_now()), 64'd0);
    check("reset wr_pulse", 64'(wr_pulse), 64'd0);
    rst_n = 1'b1;
    clks(10);
    check("post-reset regs", 64'(regs_now()), 64'd0);
    check("post-reset pulses", 64'(pulse_cnt), 64'd0);

    // Table of single frames
    for (int i = 0; i < 13; i++) begin
      run_frame($sformatf("vec%0d", i), vecs[i].val, vecs[i].nbits, vecs[i].coinc,
                vecs[i].pulse, vecs[i].regs);
    end

    // Back-to-back writes to the duty register
    p0 = pulse_cnt;
    run_frame("b2b first", 64'h8411, 16, 1'b0, 1'b1, 40'hF0_A5_0F_C3_11);
    run_frame("b2b second", 64'h8422, 16, 1'b0, 1'b1, 40'hF0_A5_0F_C3_22);
    check("b2b total pulses", 64'(pulse_cnt - p0), 64'd2);

    // Reset in the middle of a frame, then a clean write
    ncs = 1'b0;
    clks(HALF);
    shift_bits(64'h108, 9);
    rst_n = 1'b0;
    clks(3);
    check("mid-frame reset regs", 64'(regs_now()), 64'd0);
    check("mid-frame reset wr_pulse", 64'(wr_pulse), 64'd0);
    ncs = 1'b1;
    sclk = 1'b0;
    copi = 1'b0;
    clks(2);
    rst_n = 1'b1;
    clks(5);
    check("after mid-frame reset regs", 64'(regs_now()), 64'd0);
    run_frame("after reset write", 64'h8433, 16, 1'b0, 1'b1, 40'h00_00_00_00_33);

    // Registers hold while idle
    clks(50);
    check("hold regs", 64'(regs_now()), 64'h00_00_00_00_33);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
